pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the 5-stage CPU.
- Tracks destination registers of in-flight instructions in DEPTH post-decode stages.
- Outputs IF/ID stall, EX bubble, branch flush and per-operand forwarding selects.
- Implements halt-drain: on hlt or a decoded halt, the pipeline empties, then `halted` latches.
- Sits beside the decode slice. Replaces ad-hoc stall wiring with one generalised block.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_fwd_match.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/control slice.
// Stage entries carry a fixed-width rd so sub-modules stay width-agnostic (REG_AW <= MAX_REG_AW).
package pipe_ctrl_pkg;

    localparam int MAX_REG_AW  = 8;
    localparam int FWD_REGFILE = 0;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } ctrl_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [MAX_REG_AW-1:0] rd;
        logic                  is_load;
    } stage_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Per-operand priority encoder: youngest in-flight producer of rs, and whether it is a not-yet-ready load.
// Latency: combinational; no backpressure of its own.
module pipe_fwd_match
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_HW  = 1,
    parameter int SELW     = 2
) (
    input  stage_entry_t [DEPTH:1]         stages,
    input  logic         [MAX_REG_AW-1:0]  rs,
    input  logic                           used,
    output logic         [SELW-1:0]        sel,
    output logic                           load_use
);

    logic found;

    // Stage 1 is searched first so the youngest producer wins.
    always_comb begin
        sel      = SELW'(FWD_REGFILE);
        load_use = 1'b0;
        found    = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && used && stages[k].valid && stages[k].wr_en &&
                stages[k].rd == rs && !(ZERO_HW != 0 && rs == '0)) begin
                found    = 1'b1;
                sel      = SELW'(k);
                load_use = stages[k].is_load && (k <= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline control: forwarding selects, load-use stall, branch flush, halt drain.
// Latency: stall/bubble/flush/fwd combinational from stage state; stage state and halted update one cycle later.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int BR_STAGE = 2,
    parameter int ZERO_HW  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hlt,
    input  logic                          id_valid,
    input  logic [REG_AW-1:0]             id_rs0,
    input  logic [REG_AW-1:0]             id_rs1,
    input  logic                          id_rs0_used,
    input  logic                          id_rs1_used,
    input  logic                          id_wr_en,
    input  logic [REG_AW-1:0]             id_rd,
    input  logic                          id_is_load,
    input  logic                          id_is_halt,
    input  logic                          br_taken,
    output logic                          stall,
    output logic                          bubble,
    output logic                          flush_ifid,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_sel0,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_sel1,
    output logic                          halted,
    output logic [15:0]                   stall_cnt
);

    localparam int SELW = $clog2(DEPTH+1);

    stage_entry_t [DEPTH:1] stages;
    stage_entry_t [DEPTH:1] stages_nxt;
    ctrl_state_e            state;

    logic load_use0;
    logic load_use1;
    logic load_use;
    logic dec_halt;
    logic inject;
    logic any_valid;

    pipe_fwd_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .ZERO_HW  (ZERO_HW),
        .SELW     (SELW)
    ) u_match0 (
        .stages   (stages),
        .rs       (MAX_REG_AW'(id_rs0)),
        .used     (id_rs0_used),
        .sel      (fwd_sel0),
        .load_use (load_use0)
    );

    pipe_fwd_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .ZERO_HW  (ZERO_HW),
        .SELW     (SELW)
    ) u_match1 (
        .stages   (stages),
        .rs       (MAX_REG_AW'(id_rs1)),
        .used     (id_rs1_used),
        .sel      (fwd_sel1),
        .load_use (load_use1)
    );

    assign load_use = load_use0 || load_use1;

    // A taken branch overrides a load-use stall: the consumer is on the wrong path anyway.
    always_comb begin
        stall      = 1'b0;
        bubble     = 1'b0;
        flush_ifid = 1'b0;
        unique case (state)
            RUN: begin
                flush_ifid = br_taken;
                bubble     = load_use || br_taken;
                stall      = load_use && !br_taken;
            end
            DRAIN: begin
                stall      = 1'b1;
                bubble     = 1'b1;
                flush_ifid = br_taken;
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: ;
        endcase
    end

    assign dec_halt = id_valid && id_is_halt && !stall && !br_taken;
    assign inject   = (state == RUN) && id_valid && !id_is_halt && !stall && !br_taken;

    always_comb begin
        any_valid = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            any_valid = any_valid || stages[k].valid;
        end
    end

    // Entries behind the resolving stage were fetched down the wrong path.
    always_comb begin
        stages_nxt = '0;
        for (int k = DEPTH; k >= 2; k--) begin
            stages_nxt[k] = stages[k-1];
            if (br_taken && k <= BR_STAGE) begin
                stages_nxt[k].valid = 1'b0;
            end
        end
        if (inject) begin
            stages_nxt[1].valid   = 1'b1;
            stages_nxt[1].wr_en   = id_wr_en;
            stages_nxt[1].rd      = MAX_REG_AW'(id_rd);
            stages_nxt[1].is_load = id_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages    <= '0;
            state     <= RUN;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            stages <= stages_nxt;
            if (state == RUN && load_use && !br_taken && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            unique case (state)
                RUN: begin
                    if (hlt || dec_halt) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!any_valid) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised + directed bench for pipe_hazard_ctrl against an in-bench pipeline model.
// A second deep instance drives the stall counter into saturation.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, hlt, id_valid, id_rs0_used, id_rs1_used, id_wr_en, id_is_load, id_is_halt, br_taken;
    logic [3:0] id_rs0, id_rs1, id_rd;
    logic       stall, bubble, flush_ifid, halted;
    logic [1:0] fwd_sel0, fwd_sel1;
    logic [15:0] stall_cnt;

    logic       b_rst;
    logic       b_stall, b_bubble, b_flush_ifid, b_halted;
    logic [4:0] b_fwd_sel0, b_fwd_sel1;
    logic [15:0] b_stall_cnt;
    bit         b_done = 1'b0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .hlt(hlt), .id_valid(id_valid),
        .id_rs0(id_rs0), .id_rs1(id_rs1), .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
        .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .id_is_halt(id_is_halt),
        .br_taken(br_taken), .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
        .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1), .halted(halted), .stall_cnt(stall_cnt)
    );

    // Every decoded instruction is "load r3 <- [r3]": 16 stall cycles per injected load.
    pipe_hazard_ctrl #(.DEPTH(16), .LOAD_LAT(16)) dut_deep (
        .clk(clk), .rst(b_rst), .hlt(1'b0), .id_valid(1'b1),
        .id_rs0(4'd3), .id_rs1(4'd0), .id_rs0_used(1'b1), .id_rs1_used(1'b0),
        .id_wr_en(1'b1), .id_rd(4'd3), .id_is_load(1'b1), .id_is_halt(1'b0),
        .br_taken(1'b0), .stall(b_stall), .bubble(b_bubble), .flush_ifid(b_flush_ifid),
        .fwd_sel0(b_fwd_sel0), .fwd_sel1(b_fwd_sel1), .halted(b_halted), .stall_cnt(b_stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Model: in-flight instruction list, index 1 = youngest (EX).
    int m_state;  // 0 run, 1 drain, 2 halted
    bit m_v[1:3], m_we[1:3], m_ld[1:3];
    int m_rd[1:3];
    int m_cnt;

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        for (int i = 1; i <= 3; i++) begin
            m_v[i] = 0; m_we[i] = 0; m_ld[i] = 0; m_rd[i] = 0;
        end
    endtask

    function automatic int youngest(input int rs, input bit used);
        if (!used || rs == 0) return 0;
        for (int i = 1; i <= 3; i++)
            if (m_v[i] && m_we[i] && m_rd[i] == rs) return i;
        return 0;
    endfunction

    task automatic dec(input bit v, input logic [3:0] rs0, input bit u0, input logic [3:0] rs1,
                       input bit u1, input bit we, input logic [3:0] rd, input bit ld, input bit ih);
        id_valid = v; id_rs0 = rs0; id_rs0_used = u0; id_rs1 = rs1; id_rs1_used = u1;
        id_wr_en = we; id_rd = rd; id_is_load = ld; id_is_halt = ih;
    endtask

    task automatic step();
        int  k0, k1;
        bit  lu, e_stall, e_bub, e_flush, inj, all_inv;
        @(negedge clk);
        k0 = youngest(int'(id_rs0), id_rs0_used);
        k1 = youngest(int'(id_rs1), id_rs1_used);
        lu = (k0 == 1 && m_ld[1]) || (k1 == 1 && m_ld[1]);
        e_stall = 0; e_bub = 0; e_flush = 0;
        if (m_state == 0) begin
            e_flush = br_taken; e_bub = lu || br_taken; e_stall = lu && !br_taken;
        end else if (m_state == 1) begin
            e_stall = 1; e_bub = 1; e_flush = br_taken;
        end else begin
            e_stall = 1;
        end
        chk("stall", stall, e_stall);
        chk("bubble", bubble, e_bub);
        chk("flush_ifid", flush_ifid, e_flush);
        chk("fwd_sel0", fwd_sel0, k0);
        chk("fwd_sel1", fwd_sel1, k1);
        chk("halted", halted, m_state == 2);
        chk("stall_cnt", stall_cnt, m_cnt);

        inj     = (m_state == 0) && id_valid && !id_is_halt && !e_stall && !br_taken;
        all_inv = !(m_v[1] || m_v[2] || m_v[3]);
        if (m_state == 0) begin
            if (lu && !br_taken && m_cnt < 65535) m_cnt++;
            if (hlt || (id_valid && id_is_halt && !e_stall && !br_taken)) m_state = 1;
        end else if (m_state == 1 && all_inv) begin
            m_state = 2;
        end
        m_v[3] = m_v[2]; m_we[3] = m_we[2]; m_rd[3] = m_rd[2]; m_ld[3] = m_ld[2];
        m_v[2] = m_v[1] && !br_taken; m_we[2] = m_we[1]; m_rd[2] = m_rd[1]; m_ld[2] = m_ld[1];
        m_v[1] = inj; m_we[1] = id_wr_en; m_rd[1] = int'(id_rd); m_ld[1] = id_is_load;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        br_taken = 0; hlt = 0;
        #2 rst = 1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_fwd0", fwd_sel0, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic fill3();
        dec(1, 1, 1, 2, 1, 1, 3, 0, 0); step();
        dec(1, 4, 1, 5, 1, 1, 7, 0, 0); step();
        dec(1, 6, 1, 6, 0, 1, 3, 1, 0); step();
    endtask

    initial begin
        int halt_cyc;
        rst = 1; hlt = 0; br_taken = 0;
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        step();  // reset state

        // ALU -> ALU forwarding from EX
        dec(1, 1, 1, 2, 1, 1, 3, 0, 0); step();
        dec(1, 3, 1, 5, 1, 1, 4, 0, 0); step();
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();

        // load-use: one stall, then forward from stage 2 on both operands
        dec(1, 1, 1, 0, 0, 1, 3, 1, 0); step();
        dec(1, 3, 1, 3, 1, 1, 6, 0, 0); step(); step();
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step(); step();

        // r3 written in stages 1 and 3, youngest wins; then the same with r0
        dec(1, 1, 1, 0, 0, 1, 3, 0, 0); step();
        dec(1, 1, 1, 0, 0, 1, 9, 0, 0); step();
        dec(1, 1, 1, 0, 0, 1, 3, 0, 0); step();
        dec(1, 3, 1, 3, 1, 1, 5, 0, 0); step();
        dec(1, 1, 1, 0, 0, 1, 0, 0, 0); step();
        dec(1, 1, 1, 0, 0, 1, 9, 0, 0); step();
        dec(1, 1, 1, 0, 0, 1, 0, 0, 0); step();
        dec(1, 0, 1, 0, 1, 1, 5, 0, 0); step();

        // branch with full pipe and a pending load-use
        fill3();
        dec(1, 3, 1, 0, 0, 1, 5, 0, 0); br_taken = 1; step();
        br_taken = 0; dec(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();

        // decoded halt drains, then holds with hlt low; reset from HALTED
        fill3();
        dec(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
        dec(1, 1, 1, 2, 1, 1, 3, 0, 0);
        repeat (7) step();
        do_reset();

        // external halt, reset mid-drain
        fill3();
        hlt = 1; step();
        hlt = 0; step();
        do_reset();

        halt_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            dec($urandom_range(0, 9) != 0,
                4'($urandom_range(0, 4)), $urandom_range(0, 3) != 0,
                4'($urandom_range(0, 4)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, 4'($urandom_range(0, 4)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
            br_taken = $urandom_range(0, 9) == 0;
            hlt      = $urandom_range(0, 299) == 0;
            step();
            halt_cyc = (m_state == 2) ? halt_cyc + 1 : 0;
            if (halt_cyc > 3 || $urandom_range(0, 499) == 0) begin
                do_reset();
                halt_cyc = 0;
            end
        end

        wait (b_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic int deep_expect(input int n);
        int s;
        s = n - (n + 16) / 17;
        return (s > 65535) ? 65535 : s;
    endfunction

    initial begin
        int edges;
        int marks[4];
        marks = '{1700, 69631, 69632, 74800};
        b_rst = 1;
        @(posedge clk);
        #1 b_rst = 0;
        edges = 0;
        for (int m = 0; m < 4; m++) begin
            while (edges < marks[m]) begin
                @(posedge clk);
                edges++;
            end
            #2;
            chk("deep_stall_cnt", b_stall_cnt, deep_expect(edges));
        end
        chk("deep_halted", b_halted, 0);
        b_done = 1;
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not complete, got %0d compared, expected completion", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
